menu_ctrl: RTL and testbench

Main-menu state machine for the drag-racing game: turns keyboard key levels into the 3-bit menu_state bus that the start-flag stage and the VGA menu renderer consume. It handles cursor movement, item selection, a pre-race countdown, the in-race state, and the post-race result screen. It sits between the keyboard decoder (upstream) and the start-game flag, game logic and menu drawing (downstream).

---
 rtl/menu_pkg.sv | 28 ++
 rtl/key_edge_detect.sv | 33 +++
 rtl/menu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_menu_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Purpose: shared menu state codes, menu item indices and key bit positions.
// Latency: none (type and constant definitions only).
// Backpressure: none; consumed by menu_ctrl, the start-flag stage and the menu renderer.
package menu_pkg;

    // 3-bit state codes seen on the menu_state bus by downstream blocks.
    typedef enum logic [2:0] {
        MENU_MAIN      = 3'd0,
        MENU_GAME      = 3'd1,
        MENU_COUNTDOWN = 3'd2,
        MENU_HELP      = 3'd3,
        MENU_CREDITS   = 3'd4,
        MENU_RESULT    = 3'd5
    } menu_state_e;

    // Menu item indices, matching the order the renderer draws them.
    localparam logic [1:0] ITEM_START   = 2'd0;
    localparam logic [1:0] ITEM_HELP    = 2'd1;
    localparam logic [1:0] ITEM_CREDITS = 2'd2;

    // Bit positions of the keys inside the packed key vector.
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_ENTER = 2;
    localparam int KEY_ESC   = 3;
    localparam int NUM_KEYS  = 4;

endpackage

// File: rtl/key_edge_detect.sv
// Purpose: rising-edge (press) detector for a vector of key levels.
// Latency: combinational press output against a one-cycle registered history.
// Backpressure: none; a press is a single-cycle pulse and is not held.
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   key_i   - key levels, synchronous to clk
//   press_o - one-cycle pulse per bit when the key goes from low to high
module key_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_i,
    output logic [WIDTH-1:0] press_o
);

    logic [WIDTH-1:0] prev_q;

    // History resets to ones so a key held through reset must be released
    // before it can produce a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '1;
        end else begin
            prev_q <= key_i;
        end
    end

    assign press_o = key_i & ~prev_q;

endmodule

// File: rtl/menu_ctrl.sv
// Purpose: main-menu FSM (cursor, selection, countdown, race, result screen) for the drag-racing game.
// Latency: a key press or game_over in cycle N is visible on the registered outputs in cycle N+1.
// Backpressure: none; inputs are levels/pulses sampled every cycle, outputs are always valid.
//
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   key_up/key_down/key_enter/key_esc - key levels from the keyboard decoder
//   game_over                         - one-cycle pulse when the race finishes
//   menu_state                        - state code (menu_pkg::menu_state_e)
//   cursor                            - highlighted menu item
//   countdown                         - seconds left in COUNTDOWN, 0 otherwise
// Optional feature: define MENU_AUTO_RETURN_EN to leave RESULT automatically
// after RESULT_SECS seconds.
module menu_ctrl
    import menu_pkg::*;
#(
    parameter int TICKS_PER_SEC = 65_000_000,
    parameter int NUM_ITEMS     = 3,
    parameter int COUNT_START   = 3,
    parameter int RESULT_SECS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_enter,
    input  logic       key_esc,
    input  logic       game_over,
    output logic [2:0] menu_state,
    output logic [1:0] cursor,
    output logic [1:0] countdown
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [1:0]    LAST_ITEM = 2'(NUM_ITEMS - 1);
    localparam logic [1:0]    CD_INIT   = 2'(COUNT_START);

    menu_state_e   state_q, state_d;
    logic [1:0]    cursor_q, cursor_d;
    logic [1:0]    cd_q, cd_d;
    logic [TW-1:0] tick_q, tick_d;

    logic [NUM_KEYS-1:0] press;
    logic up_p, down_p, enter_p, esc_p;
    logic tick_wrap;

`ifdef MENU_AUTO_RETURN_EN
    localparam int SW = (RESULT_SECS > 1) ? $clog2(RESULT_SECS) : 1;
    localparam logic [SW-1:0] SECS_LAST = SW'(RESULT_SECS - 1);
    logic [SW-1:0] secs_q, secs_d;
`else
    // Keeps the auto-return parameter referenced when the feature is off.
    logic [31:0] cfg_unused;
    assign cfg_unused = 32'(RESULT_SECS);
`endif

    key_edge_detect #(
        .WIDTH(NUM_KEYS)
    ) u_key_edge (
        .clk     (clk),
        .rst     (rst),
        .key_i   ({key_esc, key_enter, key_down, key_up}),
        .press_o (press)
    );

    assign up_p      = press[KEY_UP];
    assign down_p    = press[KEY_DOWN];
    assign enter_p   = press[KEY_ENTER];
    assign esc_p     = press[KEY_ESC];
    assign tick_wrap = (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MENU_MAIN;
            cursor_q <= '0;
            cd_q     <= '0;
            tick_q   <= '0;
`ifdef MENU_AUTO_RETURN_EN
            secs_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            cd_q     <= cd_d;
            tick_q   <= tick_d;
`ifdef MENU_AUTO_RETURN_EN
            secs_q   <= secs_d;
`endif
        end
    end

    // tick_d defaults to zero: the counter only advances while a timed state
    // is held, so every state change (and every second boundary) clears it.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        cd_d     = cd_q;
        tick_d   = '0;
`ifdef MENU_AUTO_RETURN_EN
        secs_d   = '0;
`endif
        case (state_q)
            MENU_MAIN: begin
                if (enter_p) begin
                    case (cursor_q)
                        ITEM_START: begin
                            state_d = MENU_COUNTDOWN;
                            cd_d    = CD_INIT;
                        end
                        ITEM_HELP:    state_d = MENU_HELP;
                        ITEM_CREDITS: state_d = MENU_CREDITS;
                        default:      state_d = MENU_MAIN;
                    endcase
                end else if (up_p && !down_p) begin
                    cursor_d = (cursor_q == 2'd0) ? LAST_ITEM : cursor_q - 2'd1;
                end else if (down_p && !up_p) begin
                    cursor_d = (cursor_q == LAST_ITEM) ? 2'd0 : cursor_q + 2'd1;
                end
            end
            MENU_COUNTDOWN: begin
                if (esc_p) begin
                    state_d = MENU_MAIN;
                    cd_d    = '0;
                end else if (tick_wrap) begin
                    if (cd_q == 2'd1) begin
                        state_d = MENU_GAME;
                        cd_d    = '0;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            MENU_GAME: begin
                // Race end wins over a simultaneous abort.
                if (game_over) begin
                    state_d = MENU_RESULT;
                end else if (esc_p) begin
                    state_d = MENU_MAIN;
                end
            end
            MENU_RESULT: begin
                if (enter_p || esc_p) begin
                    state_d  = MENU_MAIN;
                    cursor_d = ITEM_START;
                end
`ifdef MENU_AUTO_RETURN_EN
                else if (tick_wrap) begin
                    if (secs_q == SECS_LAST) begin
                        state_d  = MENU_MAIN;
                        cursor_d = ITEM_START;
                    end else begin
                        secs_d = secs_q + SW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                    secs_d = secs_q;
                end
`endif
            end
            MENU_HELP, MENU_CREDITS: begin
                if (enter_p || esc_p) begin
                    state_d = MENU_MAIN;
                end
            end
            default: begin
                state_d  = MENU_MAIN;
                cursor_d = '0;
                cd_d     = '0;
            end
        endcase
    end

    assign menu_state = state_q;
    assign cursor     = cursor_q;
    assign countdown  = cd_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Purpose: self-checking bench for menu_ctrl against a behavioural menu model.
// Latency: outputs compared every falling edge; directed checks 2 time units after rising edges.
// Backpressure: none; all waits are fixed cycle counts.
module tb_menu_ctrl;

    localparam int TPS = 10;
    localparam int NI  = 3;
    localparam int CS  = 3;
    localparam int RS  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic       key_enter = 1'b0;
    logic       key_esc = 1'b0;
    logic       game_over = 1'b0;
    logic [2:0] menu_state;
    logic [1:0] cursor;
    logic [1:0] countdown;

    always #5 clk = ~clk;

    menu_ctrl #(
        .TICKS_PER_SEC(TPS),
        .NUM_ITEMS    (NI),
        .COUNT_START  (CS),
        .RESULT_SECS  (RS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_enter (key_enter),
        .key_esc   (key_esc),
        .game_over (game_over),
        .menu_state(menu_state),
        .cursor    (cursor),
        .countdown (countdown)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: time spent in a timed state is tracked as elapsed
    // cycles, and the seconds shown are derived from it arithmetically.
    int       m_state = 0;
    int       m_cursor = 0;
    int       m_cd = 0;
    int       m_elapsed = 0;
    bit [3:0] m_prev = 4'hF;

    always @(posedge clk) begin : model
        bit [3:0] keys;
        bit [3:0] pr;
        int ns;
        keys = {key_esc, key_enter, key_down, key_up};
        pr = keys & ~m_prev;
        m_prev = keys;
        if (rst) begin
            m_state = 0; m_cursor = 0; m_cd = 0; m_elapsed = 0; m_prev = 4'hF;
        end else begin
            ns = m_state;
            case (m_state)
                0: begin
                    if (pr[2]) begin
                        if (m_cursor == 0) begin ns = 2; m_cd = CS; end
                        else if (m_cursor == 1) ns = 3;
                        else ns = 4;
                    end else if (pr[0] && !pr[1]) begin
                        m_cursor = (m_cursor + NI - 1) % NI;
                    end else if (pr[1] && !pr[0]) begin
                        m_cursor = (m_cursor + 1) % NI;
                    end
                end
                2: begin
                    if (pr[3]) begin
                        ns = 0; m_cd = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed >= CS * TPS) begin ns = 1; m_cd = 0; end
                        else m_cd = CS - m_elapsed / TPS;
                    end
                end
                1: begin
                    if (game_over) ns = 5;
                    else if (pr[3]) ns = 0;
                end
                5: begin
                    if (pr[2] || pr[3]) begin
                        ns = 0; m_cursor = 0;
                    end
`ifdef MENU_AUTO_RETURN_EN
                    else begin
                        m_elapsed++;
                        if (m_elapsed >= RS * TPS) begin ns = 0; m_cursor = 0; end
                    end
`endif
                end
                3, 4: begin
                    if (pr[2] || pr[3]) ns = 0;
                end
                default: ns = 0;
            endcase
            if (ns != m_state) m_elapsed = 0;
            m_state = ns;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_state", int'(menu_state), m_state);
            check("model_cursor", int'(cursor), m_cursor);
            check("model_countdown", int'(countdown), m_cd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One idle cycle so the key is seen low, then hold for exactly one edge.
    task automatic press(input bit up, input bit down, input bit enter, input bit esc);
        step(1);
        key_up = up; key_down = down; key_enter = enter; key_esc = esc;
        step(1);
        key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0; key_esc = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_enter = 1'b1;
        step(2);
        chk_en = 1'b1;
        check("rst_state", int'(menu_state), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_countdown", int'(countdown), 0);

        rst = 1'b0;
        step(2);
        check("held_enter_ignored", int'(menu_state), 0);
        key_enter = 1'b0;

        press(0, 0, 1, 0);
        check("enter_to_countdown", int'(menu_state), 2);
        check("countdown_start", int'(countdown), 3);
        step(4);
        press(0, 0, 0, 1);
        check("esc_countdown_state", int'(menu_state), 0);
        check("esc_countdown_cd", int'(countdown), 0);

        press(0, 1, 0, 0); check("down1", int'(cursor), 1);
        press(0, 1, 0, 0); check("down2", int'(cursor), 2);
        press(0, 1, 0, 0); check("down_wrap", int'(cursor), 0);
        press(1, 0, 0, 0); check("up_wrap", int'(cursor), 2);
        press(1, 1, 0, 0); check("up_down_same", int'(cursor), 2);
        press(0, 1, 0, 0); check("down_wrap2", int'(cursor), 0);

        press(0, 0, 1, 0);
        check("cd_3", int'(countdown), 3);
        step(10); check("cd_2", int'(countdown), 2);
        step(10); check("cd_1", int'(countdown), 1);
        step(9);
        check("cd_29_state", int'(menu_state), 2);
        step(1);
        check("game_at_30", int'(menu_state), 1);
        check("game_cd_zero", int'(countdown), 0);

        game_over = 1'b1; key_esc = 1'b1;
        step(1);
        game_over = 1'b0; key_esc = 1'b0;
        check("game_over_beats_esc", int'(menu_state), 5);
`ifdef MENU_AUTO_RETURN_EN
        step(49);
        check("result_at_49", int'(menu_state), 5);
        step(1);
        check("auto_return", int'(menu_state), 0);
        check("auto_return_cursor", int'(cursor), 0);
`else
        step(200);
        check("result_held", int'(menu_state), 5);
        press(0, 0, 1, 0);
        check("result_enter", int'(menu_state), 0);
        check("result_cursor", int'(cursor), 0);
`endif

        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        check("game_over_in_main", int'(menu_state), 0);

        press(0, 1, 0, 0);
        press(0, 0, 1, 0); check("enter_help", int'(menu_state), 3);
        press(0, 0, 0, 1); check("esc_help", int'(menu_state), 0);
        check("help_cursor_kept", int'(cursor), 1);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0); check("enter_credits", int'(menu_state), 4);
        press(0, 0, 1, 0); check("credits_exit", int'(menu_state), 0);
        check("credits_cursor_kept", int'(cursor), 2);

        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        step(30);
        check("game_again", int'(menu_state), 1);
        press(0, 0, 0, 1);
        check("esc_abort_game", int'(menu_state), 0);

        press(0, 0, 1, 0);
        step(5);
        press(0, 1, 0, 0);
        check("down_ignored_in_cd", int'(cursor), 0);
        rst = 1'b1;
        step(1);
        check("mid_rst_state", int'(menu_state), 0);
        check("mid_rst_cursor", int'(cursor), 0);
        check("mid_rst_cd", int'(countdown), 0);
        rst = 1'b0;
        step(3);
        check("post_rst_state", int'(menu_state), 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
